hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage RV32 core. Detects load-use and serialising-instruction hazards at decode,

---
 rtl/hazard_if.sv | 49 ++++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Decode/execute/memory hazard signals exchanged between the pipeline datapath and hazard_ctrl.
// The datapath drives the stage information (master); the sequencer returns stage controls (slave).
interface hazard_if #(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic             id_serial;
   logic [4:0]       ex_rs1;
   logic [4:0]       ex_rs2;
   logic [4:0]       ex_rd;
   logic             ex_memread;
   logic             ex_redirect;
   logic [4:0]       mem_rd;
   logic [4:0]       wb_rd;
   logic             mem_regwrite;
   logic             wb_regwrite;
   logic             dmem_busy;
   logic             pc_stall;
   logic             if_id_stall;
   logic             id_ex_stall;
   logic             ex_mem_stall;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] cnt_stall;
   logic [CNT_W-1:0] cnt_flush;
   logic [CNT_W-1:0] cnt_freeze;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_serial,
             ex_rs1, ex_rs2, ex_rd, ex_memread, ex_redirect,
             mem_rd, wb_rd, mem_regwrite, wb_regwrite, dmem_busy,
      input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush,
             fwd_a, fwd_b, cnt_stall, cnt_flush, cnt_freeze
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_serial,
             ex_rs1, ex_rs2, ex_rd, ex_memread, ex_redirect,
             mem_rd, wb_rd, mem_regwrite, wb_regwrite, dmem_busy,
      output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush,
             fwd_a, fwd_b, cnt_stall, cnt_flush, cnt_freeze
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32 core: load-use / serialising stalls, redirect flushes,
// memory freeze, EX operand forwarding and saturating performance counters.
module hazard_ctrl #(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic     clk,
   input  logic     rst,
   hazard_if.slave  hz
);
   typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [3:0]       dcnt_q, dcnt_d;
   logic [CNT_W-1:0] cnt_stall_q, cnt_flush_q, cnt_freeze_q;

   logic lu_s, stall_pat_s, freeze_s, redirect_s;
   logic inc_stall_s, inc_flush_s, inc_freeze_s;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic mem_wr,
                                          input logic [4:0] mem_rd, input logic wb_wr,
                                          input logic [4:0] wb_rd);
      if (mem_wr && (mem_rd != 5'd0) && (mem_rd == rs)) begin
         return 2'b10;
      end else if (wb_wr && (wb_rd != 5'd0) && (wb_rd == rs)) begin
         return 2'b01;
      end else begin
         return 2'b00;
      end
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      if (en && (v != {CNT_W{1'b1}})) begin
         return v + CNT_W'(1);
      end else begin
         return v;
      end
   endfunction

   assign lu_s = hz.ex_memread && (hz.ex_rd != 5'd0) && hz.id_valid &&
                 ((hz.id_use_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                  (hz.id_use_rs2 && (hz.ex_rd == hz.id_rs2)));

   // Priority resolution: freeze, then redirect, then drain/load-use, then serial entry.
   always_comb begin
      state_d      = state_q;
      dcnt_d       = dcnt_q;
      stall_pat_s  = 1'b0;
      freeze_s     = 1'b0;
      redirect_s   = 1'b0;
      if (hz.dmem_busy) begin
         freeze_s = 1'b1;
      end else if (hz.ex_redirect) begin
         redirect_s = 1'b1;
         state_d    = RUN;
         dcnt_d     = 4'd0;
      end else begin
         case (state_q)
            DRAIN: begin
               if (dcnt_q != 4'd0) begin
                  stall_pat_s = 1'b1;
                  dcnt_d      = dcnt_q - 4'd1;
               end else begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (lu_s) begin
                  stall_pat_s = 1'b1;
               end else if (hz.id_valid && hz.id_serial) begin
                  stall_pat_s = 1'b1;
                  dcnt_d      = 4'(DRAIN_CYCLES - 1);
                  state_d     = DRAIN;
               end else begin
                  stall_pat_s = 1'b0;
               end
            end
            default: begin
               state_d = RUN;
               dcnt_d  = 4'd0;
            end
         endcase
      end
   end

   assign inc_stall_s  = stall_pat_s;
   assign inc_flush_s  = redirect_s;
   assign inc_freeze_s = freeze_s;

   // Sequencer state and event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RUN;
         dcnt_q       <= 4'd0;
         cnt_stall_q  <= '0;
         cnt_flush_q  <= '0;
         cnt_freeze_q <= '0;
      end else begin
         state_q      <= state_d;
         dcnt_q       <= dcnt_d;
         cnt_stall_q  <= sat_inc(cnt_stall_q, inc_stall_s);
         cnt_flush_q  <= sat_inc(cnt_flush_q, inc_flush_s);
         cnt_freeze_q <= sat_inc(cnt_freeze_q, inc_freeze_s);
      end
   end

   // Controls are gated by rst so a reset mid-drain/freeze releases the pipe in the same cycle.
   assign hz.pc_stall     = !rst && (freeze_s || stall_pat_s);
   assign hz.if_id_stall  = !rst && (freeze_s || stall_pat_s);
   assign hz.id_ex_stall  = !rst && freeze_s;
   assign hz.ex_mem_stall = !rst && freeze_s;
   assign hz.if_id_flush  = !rst && redirect_s;
   assign hz.id_ex_flush  = !rst && (redirect_s || stall_pat_s);

   assign hz.fwd_a = fwd_sel(hz.ex_rs1, hz.mem_regwrite, hz.mem_rd, hz.wb_regwrite, hz.wb_rd);
   assign hz.fwd_b = fwd_sel(hz.ex_rs2, hz.mem_regwrite, hz.mem_rd, hz.wb_regwrite, hz.wb_rd);

   assign hz.cnt_stall  = cnt_stall_q;
   assign hz.cnt_flush  = cnt_flush_q;
   assign hz.cnt_freeze = cnt_freeze_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed stage patterns push hand-computed expectations,
// a negedge monitor pops and compares controls, forwarding selects and counters.
module tb_hazard_ctrl;
   localparam int CW = 4;
   localparam logic [5:0] C_NONE  = 6'b000000;
   localparam logic [5:0] C_STALL = 6'b110001;
   localparam logic [5:0] C_FRZ   = 6'b111100;
   localparam logic [5:0] C_RED   = 6'b000011;

   typedef struct {
      int          id;
      logic [5:0]  ctl;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [CW-1:0] cs;
      logic [CW-1:0] cf;
      logic [CW-1:0] cz;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t q[$];
   int   step_id   = 0;
   int   checks    = 0;
   int   failures  = 0;
   bit   stim_done = 1'b0;

   hazard_if #(.CNT_W(CW)) hz ();

   hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   always #5 clk = ~clk;

   task automatic idle();
      hz.id_valid = 1'b0; hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0;
      hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0; hz.id_serial = 1'b0;
      hz.ex_rs1 = 5'd0; hz.ex_rs2 = 5'd0; hz.ex_rd = 5'd0;
      hz.ex_memread = 1'b0; hz.ex_redirect = 1'b0;
      hz.mem_rd = 5'd0; hz.wb_rd = 5'd0;
      hz.mem_regwrite = 1'b0; hz.wb_regwrite = 1'b0; hz.dmem_busy = 1'b0;
   endtask

   // lw x5 in EX, add x6,x5,x1 in ID
   task automatic lu_on();
      hz.ex_memread = 1'b1; hz.ex_rd = 5'd5;
      hz.id_valid = 1'b1; hz.id_rs1 = 5'd5; hz.id_rs2 = 5'd1;
      hz.id_use_rs1 = 1'b1; hz.id_use_rs2 = 1'b1;
   endtask

   task automatic chk(input logic [5:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                      input int cs, input int cf, input int cz);
      exp_t e;
      e.id = step_id; e.ctl = ctl; e.fa = fa; e.fb = fb;
      e.cs = CW'(cs); e.cf = CW'(cf); e.cz = CW'(cz);
      q.push_back(e);
      step_id++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      chk(C_NONE, 2'b00, 2'b00, 0, 0, 0);
      rst = 1'b0;
   endtask

   initial begin
      idle();
      @(posedge clk);
      #1;
      do_reset();

      // load-use: one bubble, then forwarding from MEM and WB
      lu_on();
      chk(C_STALL, 2'b00, 2'b00, 0, 0, 0);
      idle();
      hz.mem_rd = 5'd5; hz.mem_regwrite = 1'b1; hz.ex_rs1 = 5'd5;
      chk(C_NONE, 2'b10, 2'b00, 1, 0, 0);
      hz.mem_regwrite = 1'b0; hz.wb_rd = 5'd5; hz.wb_regwrite = 1'b1; hz.ex_rs2 = 5'd5;
      chk(C_NONE, 2'b01, 2'b01, 1, 0, 0);

      // MEM beats WB; x0 never forwarded
      idle();
      hz.ex_rs1 = 5'd7; hz.ex_rs2 = 5'd3;
      hz.mem_rd = 5'd7; hz.mem_regwrite = 1'b1; hz.wb_rd = 5'd7; hz.wb_regwrite = 1'b1;
      chk(C_NONE, 2'b10, 2'b00, 1, 0, 0);
      hz.mem_rd = 5'd0; hz.wb_rd = 5'd0; hz.ex_rs1 = 5'd0; hz.ex_rs2 = 5'd0;
      chk(C_NONE, 2'b00, 2'b00, 1, 0, 0);
      hz.wb_rd = 5'd7; hz.ex_rs2 = 5'd7;
      chk(C_NONE, 2'b00, 2'b01, 1, 0, 0);

      // serialising instruction drains for 3 cycles
      do_reset();
      hz.id_valid = 1'b1; hz.id_serial = 1'b1;
      chk(C_STALL, 2'b00, 2'b00, 0, 0, 0);
      chk(C_STALL, 2'b00, 2'b00, 1, 0, 0);
      chk(C_STALL, 2'b00, 2'b00, 2, 0, 0);
      chk(C_NONE,  2'b00, 2'b00, 3, 0, 0);
      idle();
      chk(C_NONE,  2'b00, 2'b00, 3, 0, 0);

      // redirect wins over load-use
      do_reset();
      lu_on();
      hz.ex_redirect = 1'b1;
      chk(C_RED,  2'b00, 2'b00, 0, 0, 0);
      idle();
      chk(C_NONE, 2'b00, 2'b00, 0, 1, 0);

      // freeze for 4 cycles while drain count is 1; a redirect during freeze is ignored
      do_reset();
      hz.id_valid = 1'b1; hz.id_serial = 1'b1;
      chk(C_STALL, 2'b00, 2'b00, 0, 0, 0);
      chk(C_STALL, 2'b00, 2'b00, 1, 0, 0);
      hz.dmem_busy = 1'b1;
      chk(C_FRZ, 2'b00, 2'b00, 2, 0, 0);
      chk(C_FRZ, 2'b00, 2'b00, 2, 0, 1);
      hz.ex_redirect = 1'b1;
      chk(C_FRZ, 2'b00, 2'b00, 2, 0, 2);
      hz.ex_redirect = 1'b0;
      chk(C_FRZ, 2'b00, 2'b00, 2, 0, 3);
      hz.dmem_busy = 1'b0;
      chk(C_STALL, 2'b00, 2'b00, 2, 0, 4);
      chk(C_NONE,  2'b00, 2'b00, 3, 0, 4);
      idle();
      chk(C_NONE,  2'b00, 2'b00, 3, 0, 4);

      // saturation of a 4-bit counter, then reset in the middle of a drain
      do_reset();
      lu_on();
      for (int i = 0; i < 21; i++) begin
         chk(C_STALL, 2'b00, 2'b00, (i > 15) ? 15 : i, 0, 0);
      end
      hz.ex_memread = 1'b0; hz.id_serial = 1'b1;
      chk(C_STALL, 2'b00, 2'b00, 15, 0, 0);
      chk(C_STALL, 2'b00, 2'b00, 15, 0, 0);
      rst = 1'b1;
      chk(C_NONE, 2'b00, 2'b00, 0, 0, 0);
      rst = 1'b0;
      idle();
      chk(C_NONE, 2'b00, 2'b00, 0, 0, 0);
      lu_on();
      chk(C_STALL, 2'b00, 2'b00, 0, 0, 0);
      idle();
      chk(C_NONE, 2'b00, 2'b00, 1, 0, 0);

      stim_done = 1'b1;
   end

   // Monitor: pops one expectation per cycle and owns the summary.
   initial begin
      exp_t e;
      logic [5:0] act_ctl;
      int drain_wait;
      drain_wait = 0;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            act_ctl = {hz.pc_stall, hz.if_id_stall, hz.id_ex_stall,
                       hz.ex_mem_stall, hz.if_id_flush, hz.id_ex_flush};
            checks++;
            if (act_ctl !== e.ctl) begin
               failures++;
               $display("FAIL ctl step=%0d actual=%b expected=%b", e.id, act_ctl, e.ctl);
            end
            checks++;
            if ({hz.fwd_a, hz.fwd_b} !== {e.fa, e.fb}) begin
               failures++;
               $display("FAIL fwd step=%0d actual=%b/%b expected=%b/%b",
                        e.id, hz.fwd_a, hz.fwd_b, e.fa, e.fb);
            end
            checks++;
            if ({hz.cnt_stall, hz.cnt_flush, hz.cnt_freeze} !== {e.cs, e.cf, e.cz}) begin
               failures++;
               $display("FAIL counters step=%0d actual=%0d/%0d/%0d expected=%0d/%0d/%0d",
                        e.id, hz.cnt_stall, hz.cnt_flush, hz.cnt_freeze, e.cs, e.cf, e.cz);
            end
         end else if (stim_done) begin
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
         end
         if (stim_done) begin
            drain_wait++;
            if (drain_wait > 20) begin
               failures++;
               $display("FAIL drain_timeout pending=%0d expected=0", q.size());
               $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
               $finish;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
